// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART transmit arbiter.
// The arbiter takes the slave view; the requesters and transmitter sit on the master side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  // Transmitter side
  logic                 uart_start;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_busy;
  logic                 uart_tx_done;

  // Status
  logic [ID_W-1:0]      grant_id;
  logic                 grant_active;
  logic                 err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy, uart_tx_done,
    output req_ready, uart_start, uart_tx_data, grant_id, grant_active, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy, uart_tx_done,
    input  req_ready, uart_start, uart_tx_data, grant_id, grant_active, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte requesters.
// A granted requester keeps the transmitter for a whole packet (until its last byte
// completes); transmit and inter-byte idle times are bounded by a saturating timeout counter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TX_TIMEOUT   = 131072,
  parameter int unsigned HOLD_TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         data_q, data_d;
  logic               last_q, last_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic               tx_expire;
  logic               hold_expire;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic               any_valid;
  logic               owner_take;
  logic [NUM_REQ-1:0] ready;
  logic               start;
  logic               err;

  // Saturating increment and the two timeout thresholds on the incremented value,
  // so a timeout fires in the TIMEOUT-th cycle spent in the waiting state.
  always_comb begin
    cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    tx_expire   = 32'(cnt_inc) >= TX_TIMEOUT;
    hold_expire = 32'(cnt_inc) >= HOLD_TIMEOUT;
  end

  // Round-robin pick: first valid index after rr_ptr_q, wrapping; rr_ptr_q itself is last.
  // Scanning from the far end lets the nearest valid index overwrite the others.
  always_comb begin
    winner    = rr_ptr_q;
    cand      = rr_ptr_q;
    any_valid = 1'b0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      cand = rr_ptr_q + ID_W'(k);
      if (bus.req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Owner may hand over its next byte only while the transmitter is free.
  always_comb begin
    owner_take = ~bus.uart_tx_busy & bus.req_valid[grant_id_q];
  end

  // Next-state, counter, latch and handshake decode.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    ready      = '0;
    start      = 1'b0;
    err        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The winner is valid by construction, so asserting ready means a transfer.
        if (!bus.uart_tx_busy && any_valid) begin
          ready[winner] = 1'b1;
          grant_id_d    = winner;
          data_d        = bus.req_data[{winner, 3'b000} +: 8];
          last_d        = bus.req_last[winner];
          state_d       = SEND;
        end
      end

      SEND: begin
        start   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        cnt_d = cnt_inc;
        // A done in the expiring cycle still counts as a normal completion.
        if (bus.uart_tx_done) begin
          if (last_q) begin
            rr_ptr_d = grant_id_q;
            state_d  = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end else if (tx_expire) begin
          err      = 1'b1;
          rr_ptr_d = grant_id_q;
          state_d  = IDLE;
        end
      end

      HOLD: begin
        if (!bus.uart_tx_busy) begin
          ready[grant_id_q] = 1'b1;
        end
        if (owner_take) begin
          data_d  = bus.req_data[{grant_id_q, 3'b000} +: 8];
          last_d  = bus.req_last[grant_id_q];
          state_d = SEND;
        end else begin
          cnt_d = cnt_inc;
          if (hold_expire) begin
            err      = 1'b1;
            rr_ptr_d = grant_id_q;
            state_d  = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any packet in flight without an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      grant_id_q <= '0;
      cnt_q      <= '0;
      data_q     <= 8'h00;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      last_q     <= last_d;
    end
  end

  // Ready is combinational from IDLE, so it is masked while reset is held.
  assign bus.req_ready    = reset ? '0 : ready;
  assign bus.uart_start   = start;
  assign bus.uart_tx_data = data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = (state_q != IDLE);
  assign bus.err_timeout  = err;

endmodule
